// File: rtl/ysyx22041405_pipe_stage_if.sv
// ----------------------------------------------------------------------------
// ysyx22041405_pipe_stage_if
// Purpose : valid/ready/data handshake bundle joining two pipeline stages.
// Signals :
//   valid  producer -> consumer  payload on data is valid
//   ready  consumer -> producer  consumer accepts payload this cycle
//   data   producer -> consumer  payload, WIDTH bits
// Modports:
//   master  producer side (drives valid/data, observes ready)
//   slave   consumer side (observes valid/data, drives ready)
// ----------------------------------------------------------------------------
interface ysyx22041405_pipe_stage_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ysyx22041405_pipe_stage.sv
// ----------------------------------------------------------------------------
// ysyx22041405_pipe_stage
// Purpose : pipeline register between two CPU stages with valid/ready
//           back-pressure, synchronous flush and an optional skid buffer.
//           Payload order is strict FIFO; an accepted word is visible on
//           the output the cycle after acceptance.
// Parameters:
//   WIDTH     payload width
//   SKID      0: one register, combinational upstream ready
//             1: main + skid register, registered upstream ready
//   RST_DATA  1: flush also zeroes the payload registers
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (drops every held entry)
//   i_flush      synchronous squash of all held entries, beats all handshakes
//   i_up         upstream handshake (slave: valid/data in, ready out)
//   o_dn         downstream handshake (master: valid/data out, ready in)
//   o_occupancy  number of entries currently held (0..2)
// ----------------------------------------------------------------------------
module ysyx22041405_pipe_stage #(
  parameter int WIDTH    = 32,
  parameter bit SKID     = 1'b1,
  parameter bit RST_DATA = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_flush,
  ysyx22041405_pipe_stage_if.slave        i_up,
  ysyx22041405_pipe_stage_if.master       o_dn,
  output logic [1:0]                      o_occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_FULL  = 2'd1,  // main register valid
    ST_SKIDF = 2'd2   // main and skid registers valid, upstream stalled
  } state_t;

  generate
    if (SKID == 1'b0) begin : g_single
      // ----------------------------------------------------------------
      // Single register. Upstream may load whenever the slot is empty or
      // is being drained this very cycle, so a full stage still streams
      // one beat per clock.
      // ----------------------------------------------------------------
      logic             r_valid;
      logic [WIDTH-1:0] r_data;
      logic             w_in_ready;
      logic             w_in_fire;

      assign w_in_ready = ~r_valid | o_dn.ready;
      assign w_in_fire  = i_up.valid & w_in_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (i_flush) begin
          r_valid <= 1'b0;
          if (RST_DATA) begin
            r_data <= '0;
          end
        end else if (w_in_fire) begin
          r_valid <= 1'b1;
          r_data  <= i_up.data;
        end else if (o_dn.ready) begin
          // Drain (a no-op when already empty).
          r_valid <= 1'b0;
        end
      end

      assign i_up.ready  = w_in_ready;
      assign o_dn.valid  = r_valid;
      assign o_dn.data   = r_data;
      assign o_occupancy = {1'b0, r_valid};

    end else begin : g_skid
      // ----------------------------------------------------------------
      // Main + skid register. Upstream ready is a flop, so it can only
      // react one cycle late; the skid register catches the one word that
      // arrives in the cycle the downstream stalls while main is full.
      // Output always comes from main, so no in->out combinational path.
      // ----------------------------------------------------------------
      state_t           r_state;
      state_t           w_state_next;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] w_main_next;
      logic [WIDTH-1:0] r_skid;
      logic [WIDTH-1:0] w_skid_next;
      logic             r_in_ready;
      logic             w_in_fire;
      logic             w_out_fire;

      assign w_in_fire  = i_up.valid & r_in_ready;
      assign w_out_fire = (r_state != ST_EMPTY) & o_dn.ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state    <= ST_EMPTY;
          r_main     <= '0;
          r_skid     <= '0;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_state_next;
          r_main     <= w_main_next;
          r_skid     <= w_skid_next;
          // Ready for next cycle is decided from the state we are entering.
          r_in_ready <= (w_state_next != ST_SKIDF);
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (i_flush) begin
          // Flush wins: a same-cycle input beat is dropped, a same-cycle
          // output beat is already owned by downstream.
          w_state_next = ST_EMPTY;
          if (RST_DATA) begin
            w_main_next = '0;
            w_skid_next = '0;
          end
        end else begin
          unique case (r_state)
            ST_EMPTY: begin
              if (w_in_fire) begin
                w_state_next = ST_FULL;
                w_main_next  = i_up.data;
              end
            end
            ST_FULL: begin
              unique case ({w_in_fire, w_out_fire})
                2'b10: begin
                  w_state_next = ST_SKIDF;
                  w_skid_next  = i_up.data;
                end
                2'b01: w_state_next = ST_EMPTY;
                2'b11: w_main_next  = i_up.data;
                default: ;
              endcase
            end
            ST_SKIDF: begin
              // Upstream is stalled here, so only the drain can happen.
              if (w_out_fire) begin
                w_state_next = ST_FULL;
                w_main_next  = r_skid;
              end
            end
            default: w_state_next = ST_EMPTY;
          endcase
        end
      end

      always_comb begin
        o_occupancy = 2'd0;
        unique case (r_state)
          ST_FULL:  o_occupancy = 2'd1;
          ST_SKIDF: o_occupancy = 2'd2;
          default:  o_occupancy = 2'd0;
        endcase
      end

      assign i_up.ready = r_in_ready;
      assign o_dn.valid = (r_state != ST_EMPTY);
      assign o_dn.data  = r_main;

`ifndef SYNTHESIS
      a_no_accept_in_skidf: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == ST_SKIDF) && i_up.valid && r_in_ready));
`endif
    end
  endgenerate

`ifndef SYNTHESIS
  a_occ_never_3: assert property (@(posedge clk) disable iff (!rst_n)
    o_occupancy != 2'd3);
`endif

endmodule

// File: tb/tb_ysyx22041405_pipe_stage.sv
module tb_ysyx22041405_pipe_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush0, flush1;
  logic [1:0] occ0, occ1;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ysyx22041405_pipe_stage_if #(.WIDTH(32)) up0 ();
  ysyx22041405_pipe_stage_if #(.WIDTH(32)) dn0 ();
  ysyx22041405_pipe_stage_if #(.WIDTH(32)) up1 ();
  ysyx22041405_pipe_stage_if #(.WIDTH(32)) dn1 ();

  // s0: single register, payload kept on flush
  ysyx22041405_pipe_stage #(.WIDTH(32), .SKID(1'b0), .RST_DATA(1'b0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush0),
    .i_up(up0), .o_dn(dn0), .o_occupancy(occ0));

  // s1: skid buffer, payload zeroed on flush
  ysyx22041405_pipe_stage #(.WIDTH(32), .SKID(1'b1), .RST_DATA(1'b1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush1),
    .i_up(up1), .o_dn(dn1), .o_occupancy(occ1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
    up0.valid = 1'b0; up0.data = '0; dn0.ready = 1'b0;
    up1.valid = 1'b0; up1.data = '0; dn1.ready = 1'b0;
    #12;
    n_vec++; if ({dn0.valid, occ0, dn0.data} !== {1'b0, 2'd0, 32'd0}) begin
      n_err++; $display("FAIL reset_s0: got v=%b occ=%0d d=%h want 0/0/0", dn0.valid, occ0, dn0.data); end
    n_vec++; if ({dn1.valid, occ1, dn1.data} !== {1'b0, 2'd0, 32'd0}) begin
      n_err++; $display("FAIL reset_s1: got v=%b occ=%0d d=%h want 0/0/0", dn1.valid, occ1, dn1.data); end
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({up0.ready, up1.ready} !== 2'b11) begin
      n_err++; $display("FAIL reset_in_ready: got s0=%b s1=%b want 1/1", up0.ready, up1.ready); end
    $display("reset done");
  endtask

  task automatic test_stream();
    dn0.ready = 1'b1; dn1.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up0.valid = 1'b1; up0.data = 32'(i);
      up1.valid = 1'b1; up1.data = 32'(i);
      @(negedge clk);
      n_vec++; if ({up0.ready, up1.ready} !== 2'b11) begin
        n_err++; $display("FAIL stream_ready[%0d]: got s0=%b s1=%b want 1/1", i, up0.ready, up1.ready); end
      tick();
      n_vec++; if ({dn0.valid, occ0, dn0.data} !== {1'b1, 2'd1, 32'(i)}) begin
        n_err++; $display("FAIL stream_s0[%0d]: got v=%b occ=%0d d=%h want 1/1/%h", i, dn0.valid, occ0, dn0.data, i); end
      n_vec++; if ({dn1.valid, occ1, dn1.data} !== {1'b1, 2'd1, 32'(i)}) begin
        n_err++; $display("FAIL stream_s1[%0d]: got v=%b occ=%0d d=%h want 1/1/%h", i, dn1.valid, occ1, dn1.data, i); end
      $display("stream beat %0d: s0=%h s1=%h", i, dn0.data, dn1.data);
    end
    up0.valid = 1'b0; up1.valid = 1'b0;
    tick();
    n_vec++; if ({dn0.valid, occ0, dn1.valid, occ1} !== 6'b0) begin
      n_err++; $display("FAIL stream_drain: got s0 v=%b occ=%0d s1 v=%b occ=%0d want empty", dn0.valid, occ0, dn1.valid, occ1); end
  endtask

  task automatic test_skid_backpressure();
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 32'hA;
    @(negedge clk);
    n_vec++; if (up1.ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_A: got %b want 1", up1.ready); end
    tick();
    up1.data = 32'hB;
    @(negedge clk);
    n_vec++; if (up1.ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_B: got %b want 1", up1.ready); end
    tick();
    up1.data = 32'hC;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++; if ({up1.ready, dn1.valid, occ1, dn1.data} !== {1'b0, 1'b1, 2'd2, 32'hA}) begin
        n_err++; $display("FAIL bp_stall[%0d]: got rdy=%b v=%b occ=%0d d=%h want 0/1/2/a", c, up1.ready, dn1.valid, occ1, dn1.data); end
      if (c == 1) dn1.ready = 1'b1;
      tick();
    end
    $display("bp out 0xa");
    @(negedge clk);
    n_vec++; if ({up1.ready, occ1, dn1.data} !== {1'b1, 2'd1, 32'hB}) begin
      n_err++; $display("FAIL bp_outB: got rdy=%b occ=%0d d=%h want 1/1/b", up1.ready, occ1, dn1.data); end
    tick();
    $display("bp out 0xb, in 0xc");
    up1.valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({dn1.valid, occ1, dn1.data} !== {1'b1, 2'd1, 32'hC}) begin
      n_err++; $display("FAIL bp_outC: got v=%b occ=%0d d=%h want 1/1/c", dn1.valid, occ1, dn1.data); end
    tick();
    $display("bp out 0xc");
    @(negedge clk);
    n_vec++; if ({dn1.valid, occ1} !== 3'b000) begin
      n_err++; $display("FAIL bp_empty: got v=%b occ=%0d want 0/0", dn1.valid, occ1); end
  endtask

  task automatic test_flush();
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 32'h11; tick();
    up1.data = 32'h22; tick();
    up1.data = 32'h33; flush1 = 1'b1;
    @(negedge clk);
    n_vec++; if (occ1 !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ: got %0d want 2", occ1); end
    tick();
    flush1 = 1'b0; up1.valid = 1'b0;
    n_vec++; if ({dn1.valid, occ1, up1.ready, dn1.data} !== {1'b0, 2'd0, 1'b1, 32'd0}) begin
      n_err++; $display("FAIL flush_occ2: got v=%b occ=%0d rdy=%b d=%h want 0/0/1/0", dn1.valid, occ1, up1.ready, dn1.data); end
    dn1.ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (dn1.valid !== 1'b0) begin
        n_err++; $display("FAIL flush_no_33[%0d]: got v=%b d=%h want v=0", c, dn1.valid, dn1.data); end
      tick();
    end
    // Flush while ready is high: the same-cycle input beat must vanish.
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 32'h44; tick();
    up1.data = 32'h55; flush1 = 1'b1; tick();
    n_vec++; if ({dn1.valid, occ1} !== 3'b000) begin
      n_err++; $display("FAIL flush_occ1: got v=%b occ=%0d want 0/0", dn1.valid, occ1); end
    up1.data = 32'h66; tick();
    n_vec++; if ({dn1.valid, occ1} !== 3'b000) begin
      n_err++; $display("FAIL flush_b2b: got v=%b occ=%0d want 0/0", dn1.valid, occ1); end
    flush1 = 1'b0; up1.valid = 1'b0; tick();
    n_vec++; if (dn1.valid !== 1'b0) begin
      n_err++; $display("FAIL flush_after: got v=%b d=%h want 0", dn1.valid, dn1.data); end
    $display("flush done");
  endtask

  task automatic test_same_cycle_s0();
    dn0.ready = 1'b0;
    up0.valid = 1'b1; up0.data = 32'h5; tick();
    up0.data = 32'h6;
    @(negedge clk);
    n_vec++; if (up0.ready !== 1'b0) begin n_err++; $display("FAIL s0_full_stall: got rdy=%b want 0", up0.ready); end
    dn0.ready = 1'b1;
    #1;
    n_vec++; if ({up0.ready, dn0.data} !== {1'b1, 32'h5}) begin
      n_err++; $display("FAIL s0_comb_ready: got rdy=%b d=%h want 1/5", up0.ready, dn0.data); end
    tick();
    n_vec++; if ({dn0.valid, dn0.data} !== {1'b1, 32'h6}) begin
      n_err++; $display("FAIL s0_no_bubble: got v=%b d=%h want 1/6", dn0.valid, dn0.data); end
    up0.valid = 1'b0; tick();
    n_vec++; if (dn0.valid !== 1'b0) begin n_err++; $display("FAIL s0_drain: got v=%b want 0", dn0.valid); end
    $display("s0 same-cycle 0x5 -> 0x6 done");
  endtask

  task automatic test_async_reset();
    dn1.ready = 1'b0; dn0.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 32'hA1;
    up0.valid = 1'b1; up0.data = 32'h99; tick();
    up1.data = 32'hA2; tick();
    up1.data = 32'h77;
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if ({dn1.valid, occ1, dn0.valid, occ0} !== 6'b0) begin
      n_err++; $display("FAIL arst_immediate: got s1 v=%b occ=%0d s0 v=%b occ=%0d want empty", dn1.valid, occ1, dn0.valid, occ0); end
    #3 rst_n = 1'b1;
    dn1.ready = 1'b1;
    #1;
    n_vec++; if (up1.ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", up1.ready); end
    tick();
    up1.valid = 1'b0; up0.valid = 1'b0; dn0.ready = 1'b1;
    n_vec++; if ({dn1.valid, occ1, dn1.data} !== {1'b1, 2'd1, 32'h77}) begin
      n_err++; $display("FAIL arst_first_beat: got v=%b occ=%0d d=%h want 1/1/77", dn1.valid, occ1, dn1.data); end
    tick();
    n_vec++; if (dn1.valid !== 1'b0) begin n_err++; $display("FAIL arst_drain: got v=%b want 0", dn1.valid); end
    $display("async reset done, first beat 0x77");
  endtask

  // Reference: each stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
  task automatic test_random();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          sz[2];
    logic [31:0] head[2];
    logic        iv[2], ir[2], ov[2], orr[2], fl[2], in_f[2], out_f[2], exp_rdy[2];
    logic [31:0] id[2], od[2];
    logic [1:0]  oc[2];
    int          n_in = 0, n_out = 0;
    @(negedge clk); rst_n = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
    up0.valid = 1'b0; up1.valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      up0.valid = ($urandom_range(0, 99) < 60); up0.data = $urandom;
      up1.valid = ($urandom_range(0, 99) < 60); up1.data = $urandom;
      dn0.ready = ($urandom_range(0, 99) < 55);
      dn1.ready = ($urandom_range(0, 99) < 55);
      flush0 = ($urandom_range(0, 99) < 3);
      flush1 = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      sz[0] = q0.size(); head[0] = (sz[0] > 0) ? q0[0] : 32'd0;
      sz[1] = q1.size(); head[1] = (sz[1] > 0) ? q1[0] : 32'd0;
      iv[0] = up0.valid; ir[0] = up0.ready; id[0] = up0.data; ov[0] = dn0.valid; orr[0] = dn0.ready;
      od[0] = dn0.data; oc[0] = occ0; fl[0] = flush0;
      iv[1] = up1.valid; ir[1] = up1.ready; id[1] = up1.data; ov[1] = dn1.valid; orr[1] = dn1.ready;
      od[1] = dn1.data; oc[1] = occ1; fl[1] = flush1;
      exp_rdy[0] = (sz[0] == 0) || orr[0];
      exp_rdy[1] = (sz[1] < 2);
      for (int k = 0; k < 2; k++) begin
        n_vec++; if ({ov[k], oc[k]} !== {sz[k] != 0, 2'(sz[k])}) begin
          n_err++; $display("FAIL rand_state s%0d cyc %0d: got v=%b occ=%0d want v=%b occ=%0d", k, cyc, ov[k], oc[k], sz[k] != 0, sz[k]); end
        n_vec++; if (ir[k] !== exp_rdy[k]) begin
          n_err++; $display("FAIL rand_ready s%0d cyc %0d: got %b want %b", k, cyc, ir[k], exp_rdy[k]); end
        if (sz[k] > 0) begin
          n_vec++; if (od[k] !== head[k]) begin
            n_err++; $display("FAIL rand_data s%0d cyc %0d: got %h want %h", k, cyc, od[k], head[k]); end
        end
        in_f[k]  = iv[k] & exp_rdy[k];
        out_f[k] = (sz[k] > 0) & orr[k];
      end
      @(posedge clk);
      if (fl[0]) q0.delete();
      else begin
        if (out_f[0]) begin void'(q0.pop_front()); n_out++; end
        if (in_f[0]) begin q0.push_back(id[0]); n_in++; end
      end
      if (fl[1]) q1.delete();
      else begin
        if (out_f[1]) begin void'(q1.pop_front()); n_out++; end
        if (in_f[1]) begin q1.push_back(id[1]); n_in++; end
      end
      #1;
    end
    flush0 = 1'b0; flush1 = 1'b0; up0.valid = 1'b0; up1.valid = 1'b0;
    $display("random done: %0d beats in, %0d beats out", n_in, n_out);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_backpressure();
    test_flush();
    test_same_cycle_s0();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
